// File: rtl/count_wrap_tracker.sv
// Extends a 4-bit up-counter sample into {wrap_cnt, cnt} and flags non-unit jumps.
// Optional stall detection is enabled by defining CNT_STALL_DETECT_EN.
module count_wrap_tracker #(
   parameter int unsigned EXT_W     = 4,
   parameter int unsigned STALL_LIM = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       cnt,
   input  logic             clr,
   output logic [EXT_W+3:0] ext_cnt,
   output logic             wrap_pulse,
   output logic             jump_err,
   output logic             stall,
   output logic [1:0]       state
);

   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_STALL = 2'd2
   } state_t;

   if (STALL_LIM < 2 || STALL_LIM > 255) begin : g_lim_check
      $error("STALL_LIM out of range 2..255");
   end

   state_t           r_state;
   state_t           w_next_state;
   logic [3:0]       r_prev;
   logic [EXT_W-1:0] r_wrap_cnt;
   logic             r_wrap_pulse;
   logic             r_jump_err;
   logic             w_active;
   logic             w_hold;
   logic             w_step;
   logic             w_wrap;
   logic             w_jump;

   assign w_active = (r_state != ST_INIT);
   assign w_hold   = (cnt == r_prev);
   assign w_wrap   = (r_prev == 4'hF) && (cnt == 4'h0);
   assign w_step   = (r_prev != 4'hF) && (cnt == r_prev + 4'd1);
   assign w_jump   = !(w_hold || w_step || w_wrap);

`ifdef CNT_STALL_DETECT_EN
   localparam logic [7:0] LP_STALL_LIM = 8'(STALL_LIM);

   logic [7:0] r_stall_cnt;
   logic [7:0] w_stall_cnt_inc;
   logic       w_stall_reached;

   assign w_stall_cnt_inc = (r_stall_cnt == 8'hFF) ? r_stall_cnt : r_stall_cnt + 8'd1;
   assign w_stall_reached = (w_stall_cnt_inc >= LP_STALL_LIM);

   // Any non-hold sample (or the INIT load) restarts the hold run.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_stall_cnt <= '0;
      end else if (w_active && w_hold) begin
         r_stall_cnt <= w_stall_cnt_inc;
      end else begin
         r_stall_cnt <= '0;
      end
   end

   assign stall = (r_state == ST_STALL);
`else
   assign stall = 1'b0;
`endif

   always_comb begin
      w_next_state = r_state;
      unique case (r_state)
         ST_INIT: w_next_state = ST_RUN;
         ST_RUN: begin
`ifdef CNT_STALL_DETECT_EN
            if (w_hold && w_stall_reached) w_next_state = ST_STALL;
`endif
         end
         ST_STALL: if (!w_hold) w_next_state = ST_RUN;
         default:  w_next_state = ST_INIT;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) r_state <= ST_INIT;
      else     r_state <= w_next_state;
   end

   // clr overrides a same-edge wrap increment or jump set, but the pulse still fires.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_prev       <= '0;
         r_wrap_cnt   <= '0;
         r_wrap_pulse <= 1'b0;
         r_jump_err   <= 1'b0;
      end else begin
         r_prev       <= cnt;
         r_wrap_pulse <= w_active && w_wrap;
         if (clr) begin
            r_wrap_cnt <= '0;
            r_jump_err <= 1'b0;
         end else begin
            if (w_active && w_wrap) r_wrap_cnt <= r_wrap_cnt + 1'b1;
            if (w_active && w_jump) r_jump_err <= 1'b1;
         end
      end
   end

   assign ext_cnt    = {r_wrap_cnt, r_prev};
   assign wrap_pulse = r_wrap_pulse;
   assign jump_err   = r_jump_err;
   assign state      = r_state;

endmodule

// File: tb/tb_count_wrap_tracker.sv
// Randomized + directed bench for count_wrap_tracker against an arithmetic reference model.
// Honors CNT_STALL_DETECT_EN the same way as the design build.
module tb_count_wrap_tracker;

   localparam int unsigned EXT_W     = 4;
   localparam int unsigned STALL_LIM = 8;
`ifdef CNT_STALL_DETECT_EN
   localparam bit STALL_EN = 1'b1;
`else
   localparam bit STALL_EN = 1'b0;
`endif

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic [3:0]       cnt = 4'd0;
   logic             clr = 1'b0;
   logic [EXT_W+3:0] ext_cnt;
   logic             wrap_pulse;
   logic             jump_err;
   logic             stall;
   logic [1:0]       state;

   count_wrap_tracker #(
      .EXT_W     (EXT_W),
      .STALL_LIM (STALL_LIM)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .cnt        (cnt),
      .clr        (clr),
      .ext_cnt    (ext_cnt),
      .wrap_pulse (wrap_pulse),
      .jump_err   (jump_err),
      .stall      (stall),
      .state      (state)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   // Reference model: plain integers, updated from the sampled inputs at each edge
   int m_init  = 1;
   int m_prev  = 0;
   int m_wraps = 0;
   int m_jerr  = 0;
   int m_pulse = 0;
   int m_holds = 0;
   int cur     = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_step(input int c, input int cl, input int r);
      int is_hold, is_step, is_wrap;
      if (r != 0) begin
         m_init = 1; m_prev = 0; m_wraps = 0; m_jerr = 0; m_pulse = 0; m_holds = 0;
      end else begin
         if (m_init != 0) begin
            m_init  = 0;
            m_pulse = 0;
            m_holds = 0;
         end else begin
            is_hold = (c == m_prev);
            is_wrap = (m_prev == 15 && c == 0);
            is_step = (m_prev < 15 && c == m_prev + 1);
            m_pulse = is_wrap;
            m_holds = is_hold ? m_holds + 1 : 0;
            if (is_wrap) m_wraps++;
            if (!is_hold && !is_step && !is_wrap) m_jerr = 1;
         end
         if (cl != 0) begin
            m_wraps = 0;
            m_jerr  = 0;
         end
         m_prev = c;
      end
   endtask

   task automatic cycle(input int c, input int cl, input int r);
      int exp_stall, exp_state;
      @(negedge clk);
      cnt = 4'(c);
      clr = (cl != 0);
      rst = (r != 0);
      @(posedge clk);
      model_step(c, cl, r);
      cur = c;
      #1;
      exp_stall = (STALL_EN && m_init == 0 && m_holds >= int'(STALL_LIM)) ? 1 : 0;
      exp_state = (m_init != 0) ? 0 : (exp_stall != 0 ? 2 : 1);
      check("ext_cnt", 32'(ext_cnt), 32'((m_wraps % (1 << EXT_W)) * 16 + m_prev));
      check("wrap_pulse", 32'(wrap_pulse), 32'(m_pulse));
      check("jump_err", 32'(jump_err), 32'(m_jerr));
      check("stall", 32'(stall), 32'(exp_stall));
      check("state", 32'(state), 32'(exp_state));
   endtask

   task automatic step_to(input int target);
      while (cur != target) cycle((cur + 1) % 16, 0, 0);
   endtask

   initial begin
      int unsigned r;
      int          len;
      int          nc;

      // Reset hold with cnt=0
      repeat (5) cycle(0, 0, 1);

      // Count through one wrap: 0..15,0,1
      for (int i = 0; i < 16; i++) cycle(i, 0, 0);
      cycle(0, 0, 0);
      check("ext_after_wrap", 32'(ext_cnt), 32'h10);
      cycle(1, 0, 0);

      // 16 further wraps bring the wrap field back around
      for (int i = 0; i < 16 * 16; i++) cycle((cur + 1) % 16, 0, 0);
      check("ext_after_16_wraps", 32'(ext_cnt), 32'h11);

      // Hold at 3 long enough to stall, then release with 4
      step_to(3);
      for (int i = 0; i < 10; i++) cycle(3, 0, 0);
      cycle(4, 0, 0);
      check("ext_lo_after_stall", 32'(ext_cnt[3:0]), 32'd4);

      // Reload jump, stickiness, then clr
      cycle(7, 0, 0);
      cycle(8, 0, 0);
      cycle(9, 0, 0);
      check("jump_sticky", 32'(jump_err), 32'd1);
      cycle(10, 1, 0);
      check("clr_upper", 32'(ext_cnt[7:4]), 32'd0);

      // Five wraps, then clr on the 15->0 edge
      for (int i = 0; i < 5 * 16; i++) cycle((cur + 1) % 16, 0, 0);
      step_to(15);
      check("wrap_cnt_5", 32'(ext_cnt[7:4]), 32'd5);
      cycle(0, 1, 0);
      check("clr_wrap_pulse", 32'(wrap_pulse), 32'd1);
      cycle(1, 0, 0);
      cycle(2, 0, 0);
      cycle(3, 0, 1);
      check("mid_rst_ext", 32'(ext_cnt), 32'd0);
      cycle(3, 0, 0);

      // Random phase: mostly steps, some hold runs, jumps, clr and rare resets
      for (int i = 0; i < 4000; i++) begin
         r = $urandom_range(0, 99);
         if (r < 4) begin
            len = int'($urandom_range(5, 12));
            for (int k = 0; k < len; k++) cycle(cur, 0, 0);
         end else begin
            if (r < 75)      nc = (cur + 1) % 16;
            else if (r < 88) nc = cur;
            else             nc = int'($urandom_range(0, 15));
            cycle(nc, ($urandom_range(0, 99) < 4) ? 1 : 0, ($urandom_range(0, 299) == 0) ? 1 : 0);
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
